dnn_weight_sequencer: RTL and testbench
=======================================

# dnn_weight_sequencer

Round-robin weight-fetch scheduler for the fully connected stage. All DNN layers share one synchronous weight memory. Each layer asks for one weight word per input value it consumes. The sequencer grants at most one layer per cycle and addresses that layer's region of the memory with a per-layer row pointer. It then returns the word tagged for the granted layer, and tracks image passes so the memory stops being read after `NumOfImages` passes.

## Interface
- `M_W_BitSize`, 16, bits per weight.
- `MaxNumNerves`, 6, weights per memory word (one per neuron lane).
- `NumLayers`, 4, number of requesting layers.
- `LNI`, `'{3,5,6,4}`, integer array `[NumLayers-1:0]`, input rows per layer. Index `l` is layer `l`, so layer 0 has 4 rows and layer 3 has 3 rows.
- `AddrWidth`, 5, memory address width. Sum of `LNI` must not exceed `2**AddrWidth`.
- `NumOfImages`, 4, image passes before `out_done`.

Ports:
- `clk`  in  1  clock.
- `res`  in  1  synchronous, active-high reset.
- `in_fl_res`  in  1  frame restart pulse: clears pointers, pass count and `out_done`.
- `in_req`  in  `NumLayers`  per-layer request level, one word per granted cycle.
- `out_grant`  out  `NumLayers`  one-hot combinational grant, same cycle as `in_req`.
- `mem_en`  out  1  registered read enable.
- `mem_addr`  out  `AddrWidth`  registered read address.
- `mem_rdata`  in  `[MaxNumNerves-1:0][M_W_BitSize-1:0]`  memory data, valid 1 cycle after `mem_en`.
- `out_weights`  out  `[MaxNumNerves-1:0][M_W_BitSize-1:0]`  passthrough of `mem_rdata`.
- `out_valid`  out  `NumLayers`  one-hot, marks the layer that owns `out_weights`.
- `out_row_last`  out  1  with `out_valid`: the word is the layer's final row.
- `out_done`  out  1  sticky, set after `NumOfImages` passes.

## Operation
- Base addresses are elaboration constants: `base[0]=0`, `base[l]=base[l-1]+LNI[l-1]`. Defaults are 0, 4, 10, 15.
- Round-robin arbitration:
  - Search starts at `last+1` (mod `NumLayers`); the first asserted `in_req` wins.
  - `last` updates to the winner on a grant.
  - Reset value of `last` is `NumLayers-1`, so layer 0 wins first.
  - No grant when `in_req` is 0 or `out_done` is 1.
- On a grant to layer `l`:
  - `mem_addr <= base[l]+ptr[l]`, `mem_en <= 1`, and the `l`-tag and last-row flag are pushed into a 2-stage pipeline.
  - `ptr[l]` increments, wrapping from `LNI[l]-1` to 0. The wrap marks the row as last.
- Pass counter (`$clog2(NumOfImages+1)` bits) increments when layer `NumLayers-1` wraps. When it reaches `NumOfImages`, `out_done <= 1` at that same edge.
- Requester rule: a layer holds `in_req` until it sees `out_grant` for each word it wants. It may keep `in_req` high for back-to-back words.
- `in_fl_res`:
  - Clears all `ptr`, the pass counter and `out_done` at the next edge. Clear wins over a same-cycle increment.
  - A grant in the same cycle still uses the pre-clear pointer.
  - Reads already in the pipeline complete normally.
- `res`: all state cleared, `last=NumLayers-1`, pipeline flushed. Reads in flight are dropped; no `out_valid` follows the reset.

## Timing
- Reset values:
  - `out_grant` follows `in_req` combinationally (0 when `in_req`=0).
  - `mem_en=0`, `mem_addr=0`, `out_valid=0`, `out_row_last=0`, `out_done=0`.
  - `out_weights` = `mem_rdata` (no reset).
- Cycle t: `in_req`/`out_grant`. Cycle t+1: `mem_en`/`mem_addr`. Cycle t+2: `out_valid`/`out_row_last` with `out_weights`.
- Latency from grant to data is 2 cycles. Throughput is one word per cycle with no bubbles between layers.
- `mem_en` is 0 in any cycle following a no-grant cycle. `mem_addr` holds its last value.
- `out_done` goes high the cycle after the final wrap grant. The final word still emerges at t+2.
- With `out_done` set and `in_req` high, `out_grant` stays 0.

## Test plan
- Single request:
  - Stimulus: reset, `in_req=0001` for 1 cycle, memory word 0 = `A`.
  - Response: `out_grant=0001` in the same cycle; `mem_en=1`, `mem_addr=0` at t+1; `out_valid=0001`, `out_weights=A`, `out_row_last=0` at t+2.
- All layers contend:
  - Stimulus: `in_req=1111` held for 8 cycles.
  - Response: grant order 0,1,2,3,0,1,2,3; addresses 0,4,10,15,1,5,11,16.
- Wrap:
  - Stimulus: layer 3 alone requests 4 words.
  - Response: addresses 15,16,17,15; `out_row_last` set on the third word only; pass count = 1.
- Frame restart collision:
  - Stimulus: layer 1 at `ptr=3`; `in_fl_res` and a layer-1 grant in the same cycle.
  - Response: that grant reads address 7; the next layer-1 grant reads address 4.
- Done:
  - Stimulus: layer 3 completes 4 passes (12 grants).
  - Response: `out_done=1` after the 12th grant; further `in_req` gets no grant; `in_fl_res` clears `out_done` and the next grant reads address 15.
- Reset mid-operation:
  - Stimulus: `res` asserted 1 cycle after a grant.
  - Response: no `out_valid` appears; all pointers are 0; the next `in_req=1111` is granted to layer 0 first.

Source files
------------

// File: rtl/dnn_weight_sequencer_if.sv
// Bus bundle between the weight sequencer, its requesting layers and the shared weight memory.
// The master side is the sequencer; the slave side is the layers plus memory.
interface dnn_weight_sequencer_if #(
    parameter int unsigned M_W_BitSize  = 16,
    parameter int unsigned MaxNumNerves = 6,
    parameter int unsigned NumLayers    = 4,
    parameter int unsigned AddrWidth    = 5
);
    logic                                     in_fl_res;
    logic [NumLayers-1:0]                     in_req;
    logic [NumLayers-1:0]                     out_grant;
    logic                                     mem_en;
    logic [AddrWidth-1:0]                     mem_addr;
    logic [MaxNumNerves-1:0][M_W_BitSize-1:0] mem_rdata;
    logic [MaxNumNerves-1:0][M_W_BitSize-1:0] out_weights;
    logic [NumLayers-1:0]                     out_valid;
    logic                                     out_row_last;
    logic                                     out_done;

    modport master (
        input  in_fl_res, in_req, mem_rdata,
        output out_grant, mem_en, mem_addr, out_weights, out_valid, out_row_last, out_done
    );

    modport slave (
        output in_fl_res, in_req, mem_rdata,
        input  out_grant, mem_en, mem_addr, out_weights, out_valid, out_row_last, out_done
    );
endinterface

// File: rtl/dnn_weight_sequencer.sv
// Round-robin weight-fetch scheduler: one layer granted per cycle, per-layer row pointers
// into a shared synchronous weight memory, two-cycle tag pipeline and image-pass tracking.
module dnn_weight_sequencer #(
    parameter int unsigned M_W_BitSize  = 16,
    parameter int unsigned MaxNumNerves = 6,
    parameter int unsigned NumLayers    = 4,
    parameter int unsigned LNI [NumLayers-1:0] = '{3, 5, 6, 4},
    parameter int unsigned AddrWidth    = 5,
    parameter int unsigned NumOfImages  = 4
) (
    input logic                   clk,
    input logic                   res,
    dnn_weight_sequencer_if.master bus
);
    localparam int unsigned LayerW = (NumLayers > 1) ? $clog2(NumLayers) : 1;
    localparam int unsigned PassW  = $clog2(NumOfImages + 1);

    function automatic int unsigned base_of(input int unsigned l);
        int unsigned s;
        s = 0;
        for (int unsigned i = 0; i < l; i++) s += LNI[i];
        return s;
    endfunction

    logic [AddrWidth-1:0] base     [NumLayers];
    logic [AddrWidth-1:0] last_row [NumLayers];
    for (genvar g = 0; g < NumLayers; g++) begin : g_const
        assign base[g]     = AddrWidth'(base_of(g));
        assign last_row[g] = AddrWidth'(LNI[g] - 1);
    end

    logic [AddrWidth-1:0] ptr_q [NumLayers];
    logic [LayerW-1:0]    last_q;
    logic [PassW-1:0]     pass_q;
    logic                 done_q;
    logic                 mem_en_q;
    logic [AddrWidth-1:0] mem_addr_q;
    logic [NumLayers-1:0] valid_s1_q, valid_s2_q;
    logic                 row_last_s1_q, row_last_s2_q;

    logic [LayerW-1:0]    win;
    logic                 found;
    logic                 wrap;
    logic [NumLayers-1:0] grant;
    int unsigned          idx;

    // Search from the layer after the last winner; first requester wins.
    always_comb begin
        win   = last_q;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 1; k <= NumLayers; k++) begin
            idx = (32'(last_q) + k) % NumLayers;
            if (!found && bus.in_req[LayerW'(idx)]) begin
                found = 1'b1;
                win   = LayerW'(idx);
            end
        end
        found = found & ~done_q;
        wrap  = (ptr_q[win] == last_row[win]);
        grant = '0;
        if (found) grant[win] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (res) begin
            for (int i = 0; i < NumLayers; i++) ptr_q[i] <= '0;
            last_q        <= LayerW'(NumLayers - 1);
            pass_q        <= '0;
            done_q        <= 1'b0;
            mem_en_q      <= 1'b0;
            mem_addr_q    <= '0;
            valid_s1_q    <= '0;
            valid_s2_q    <= '0;
            row_last_s1_q <= 1'b0;
            row_last_s2_q <= 1'b0;
        end else begin
            mem_en_q      <= found;
            valid_s1_q    <= grant;
            row_last_s1_q <= found & wrap;
            valid_s2_q    <= valid_s1_q;
            row_last_s2_q <= row_last_s1_q;
            if (found) begin
                mem_addr_q <= base[win] + ptr_q[win];
                last_q     <= win;
                ptr_q[win] <= wrap ? '0 : ptr_q[win] + 1'b1;
                if (wrap && (win == LayerW'(NumLayers - 1))) begin
                    pass_q <= pass_q + 1'b1;
                    if (pass_q == PassW'(NumOfImages - 1)) done_q <= 1'b1;
                end
            end
            // Frame restart overrides any same-cycle pointer or pass update.
            if (bus.in_fl_res) begin
                for (int i = 0; i < NumLayers; i++) ptr_q[i] <= '0;
                pass_q <= '0;
                done_q <= 1'b0;
            end
        end
    end

    assign bus.out_grant    = grant;
    assign bus.mem_en       = mem_en_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.out_weights  = bus.mem_rdata;
    assign bus.out_valid    = valid_s2_q;
    assign bus.out_row_last = row_last_s2_q;
    assign bus.out_done     = done_q;
endmodule

// File: tb/tb_dnn_weight_sequencer.sv
// Randomized and directed bench for dnn_weight_sequencer against a cycle-level behavioural model.
module tb_dnn_weight_sequencer;
    logic clk = 1'b0;
    logic res = 1'b1;
    always #5 clk = ~clk;

    dnn_weight_sequencer_if bus ();

    dnn_weight_sequencer dut (
        .clk (clk),
        .res (res),
        .bus (bus)
    );

    int ROWS [4] = '{4, 6, 5, 3};
    int BASE [4] = '{0, 4, 10, 15};

    logic [95:0] mem [32];
    always @(posedge clk) if (bus.mem_en) bus.mem_rdata <= mem[bus.mem_addr];

    int tests = 0;
    int fails = 0;
    bit check_en = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model state: the values the registered outputs must show in the current cycle.
    int          m_ptr [4];
    int          m_last = 3, m_pass = 0;
    bit          m_done = 0, m_en = 0, m_rl1 = 0, m_rl2 = 0;
    int          m_addr = 0;
    logic [3:0]  m_v1 = 0, m_v2 = 0;
    logic [95:0] m_w2;
    int          g;
    logic [3:0]  eg;

    int grant_log[$], addr_log[$], vtag_log[$], rl_log[$];

    always @(negedge clk) begin
        if (check_en) begin
            chk("mem_en", bus.mem_en, m_en);
            chk("mem_addr", bus.mem_addr, m_addr);
            chk("out_valid", bus.out_valid, m_v2);
            chk("out_row_last", bus.out_row_last, m_rl2);
            if (m_v2 != 0) chk("out_weights", bus.out_weights, m_w2);
            chk("out_done", bus.out_done, m_done);
        end
        g = -1;
        if (!m_done)
            for (int k = 1; k <= 4; k++)
                if (g < 0 && bus.in_req[(m_last + k) % 4]) g = (m_last + k) % 4;
        eg = 4'b0;
        if (g >= 0) eg[g] = 1'b1;
        if (check_en) chk("out_grant", bus.out_grant, eg);

        for (int i = 0; i < 4; i++) begin
            if (bus.out_grant[i]) grant_log.push_back(i);
            if (bus.out_valid[i]) vtag_log.push_back(i);
        end
        if (bus.mem_en) addr_log.push_back(int'(bus.mem_addr));
        if (bus.out_valid != 0) rl_log.push_back(int'(bus.out_row_last));

        if (res) begin
            for (int i = 0; i < 4; i++) m_ptr[i] = 0;
            m_last = 3; m_pass = 0; m_done = 0; m_en = 0; m_addr = 0;
            m_v1 = 0; m_v2 = 0; m_rl1 = 0; m_rl2 = 0;
        end else begin
            if (m_en) m_w2 = mem[m_addr];
            m_v2 = m_v1; m_rl2 = m_rl1;
            m_en = (g >= 0); m_v1 = eg; m_rl1 = 0;
            if (g >= 0) begin
                m_addr = BASE[g] + m_ptr[g];
                m_last = g;
                m_ptr[g]++;
                if (m_ptr[g] == ROWS[g]) begin
                    m_ptr[g] = 0;
                    m_rl1 = 1;
                    if (g == 3) begin
                        m_pass++;
                        if (m_pass == 4) m_done = 1;
                    end
                end
            end
            if (bus.in_fl_res) begin
                for (int i = 0; i < 4; i++) m_ptr[i] = 0;
                m_pass = 0; m_done = 0;
            end
        end
    end

    task automatic step(input logic [3:0] req, input logic fl, input logic r);
        bus.in_req = req; bus.in_fl_res = fl; res = r;
        @(posedge clk); #1;
    endtask

    task automatic clear_logs();
        grant_log.delete(); addr_log.delete(); vtag_log.delete(); rl_log.delete();
    endtask

    task automatic rst_pulse();
        step(4'b0, 1'b0, 1'b1);
        clear_logs();
    endtask

    task automatic drain();
        repeat (3) step(4'b0, 1'b0, 1'b0);
    endtask

    task automatic check_q(input string nm, input int act[$], input int exp[$]);
        chk({nm, "_len"}, act.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            chk(nm, (i < act.size()) ? act[i] : -1, exp[i]);
    endtask

    int e[$];

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = {$urandom, $urandom, $urandom};
        bus.in_req = 4'b0; bus.in_fl_res = 1'b0; bus.mem_rdata = '0;
        step(4'b0, 1'b0, 1'b1);
        step(4'b0, 1'b0, 1'b1);
        check_en = 1'b1;
        step(4'b0, 1'b0, 1'b0);
        #3;
        chk("rst_mem_en", bus.mem_en, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, 5'd0);
        chk("rst_valid", bus.out_valid, 4'b0);
        chk("rst_row_last", bus.out_row_last, 1'b0);
        chk("rst_done", bus.out_done, 1'b0);
        chk("rst_grant", bus.out_grant, 4'b0);

        // Single request
        rst_pulse();
        step(4'b0001, 1'b0, 1'b0);
        drain();
        e = '{0}; check_q("single_grant", grant_log, e);
        e = '{0}; check_q("single_addr", addr_log, e);
        e = '{0}; check_q("single_vtag", vtag_log, e);
        e = '{0}; check_q("single_rl", rl_log, e);

        // All layers contend
        rst_pulse();
        repeat (8) step(4'b1111, 1'b0, 1'b0);
        drain();
        e = '{0, 1, 2, 3, 0, 1, 2, 3}; check_q("rr_grant", grant_log, e);
        e = '{0, 4, 10, 15, 1, 5, 11, 16}; check_q("rr_addr", addr_log, e);

        // Layer 3 wrap
        rst_pulse();
        repeat (4) step(4'b1000, 1'b0, 1'b0);
        drain();
        e = '{15, 16, 17, 15}; check_q("wrap_addr", addr_log, e);
        e = '{0, 0, 1, 0}; check_q("wrap_rl", rl_log, e);

        // Frame restart colliding with a grant
        rst_pulse();
        repeat (3) step(4'b0010, 1'b0, 1'b0);
        step(4'b0010, 1'b1, 1'b0);
        step(4'b0010, 1'b0, 1'b0);
        drain();
        e = '{4, 5, 6, 7, 4}; check_q("flres_addr", addr_log, e);

        // Done after four passes of layer 3
        rst_pulse();
        repeat (12) step(4'b1000, 1'b0, 1'b0);
        repeat (3) step(4'b1000, 1'b0, 1'b0);
        #3;
        chk("done_set", bus.out_done, 1'b1);
        chk("done_grants", grant_log.size(), 12);
        chk("done_blocks_grant", bus.out_grant, 4'b0);
        step(4'b0000, 1'b1, 1'b0);
        step(4'b1000, 1'b0, 1'b0);
        drain();
        #3;
        chk("done_cleared", bus.out_done, 1'b0);
        chk("done_next_addr", addr_log[addr_log.size()-1], 15);

        // Reset one cycle after a grant
        rst_pulse();
        step(4'b0100, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b1);
        drain();
        chk("midrst_no_valid", vtag_log.size(), 0);
        clear_logs();
        repeat (3) step(4'b1111, 1'b0, 1'b0);
        drain();
        e = '{0, 1, 2}; check_q("midrst_grant", grant_log, e);
        e = '{0, 4, 10}; check_q("midrst_addr", addr_log, e);

        // Random traffic, frame restarts and resets
        for (int n = 0; n < 3000; n++)
            step(4'($urandom), ($urandom_range(0, 39) == 0), ($urandom_range(0, 299) == 0));
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
